// File: rtl/mealy_dec_pkg.sv
// Shared types and decode constants for the mealy_dec state machine.
// The seven output codes are named by (state, in) so the decoder table reads directly.
package mealy_dec_pkg;

  typedef enum logic [1:0] {
    S_A = 2'b00,
    S_B = 2'b01,
    S_C = 2'b10,
    S_D = 2'b11
  } state_t;

  typedef logic [2:0] out_t;

  // D produces the same code for both input values, hence only seven entries
  localparam out_t OUT_A0 = 3'b111;
  localparam out_t OUT_A1 = 3'b101;
  localparam out_t OUT_B0 = 3'b001;
  localparam out_t OUT_B1 = 3'b011;
  localparam out_t OUT_C0 = 3'b000;
  localparam out_t OUT_C1 = 3'b100;
  localparam out_t OUT_D  = 3'b110;

endpackage

// File: rtl/mealy_out_dec.sv
// Clockless Mealy output decoder: out is a pure function of the current state and in.
module mealy_out_dec
  import mealy_dec_pkg::*;
(
  input  logic [1:0] state,
  input  logic       in,
  output logic [2:0] out
);

  out_t out_s;

  // Full (state, in) table; every encoding is legal so nothing decodes to X
  always_comb begin
    out_s = OUT_A0;
    case (state_t'(state))
      S_A:     out_s = in ? OUT_A1 : OUT_A0;
      S_B:     out_s = in ? OUT_B1 : OUT_B0;
      S_C:     out_s = in ? OUT_C1 : OUT_C0;
      S_D:     out_s = OUT_D;
      default: out_s = OUT_A0;
    endcase
  end

  assign out = out_s;

endmodule

// File: rtl/mealy_dec.sv
// Four-state Mealy machine: registered state with asynchronous reset, plus a
// combinational output decoder so out reacts to in within the same cycle.
module mealy_dec
  import mealy_dec_pkg::*;
#(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic [1:0] state,
  output logic [2:0] out
);

  state_t state_r;

  // State register and next-state table; reset drops any pending transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= state_t'(RESET_STATE);
    end else begin
      case (state_r)
        S_A:     state_r <= in ? S_C : S_B;
        S_B:     state_r <= in ? S_D : S_C;
        S_C:     state_r <= in ? S_A : S_D;
        S_D:     state_r <= in ? S_D : S_A;
        default: state_r <= state_t'(RESET_STATE);
      endcase
    end
  end

  assign state = state_r;

  mealy_out_dec u_out_dec (
    .state (state_r),
    .in    (in),
    .out   (out)
  );

endmodule

// File: tb/tb_mealy_dec.sv
// Directed plus random-walk bench for mealy_dec with a queue-based scoreboard.
module tb_mealy_dec;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic [1:0] state;
  logic [2:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [2:0] o;
  } exp_t;

  exp_t sb[$];

  mealy_dec #(.RESET_STATE(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .state (state),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table written straight from the decode requirements
  function automatic logic [2:0] model_out(input logic [1:0] s, input logic i);
    case ({s, i})
      3'b000:  return 3'b111;
      3'b001:  return 3'b101;
      3'b010:  return 3'b001;
      3'b011:  return 3'b011;
      3'b100:  return 3'b000;
      3'b101:  return 3'b100;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [1:0] model_next(input logic [1:0] s, input logic i);
    case ({s, i})
      3'b000:  return 2'b01;
      3'b001:  return 2'b10;
      3'b010:  return 2'b10;
      3'b011:  return 2'b11;
      3'b100:  return 2'b11;
      3'b101:  return 2'b00;
      3'b110:  return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  // Push the expectation, let combinational logic settle, then pop and compare
  task automatic step_check(input string tag, input logic [1:0] st, input logic [2:0] o);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.o   = o;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (state === e.st) else begin
        errors++;
        $error("FAIL %s_state: observed %b expected %b", e.tag, state, e.st);
      end
      checks++;
      assert (out === e.o) else begin
        errors++;
        $error("FAIL %s_out: observed %b expected %b", e.tag, out, e.o);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mst;
    rst_n = 1'b0;
    in    = 1'b0;
    #2;
    step_check("rst_in0", 2'b00, 3'b111);
    in = 1'b1;
    step_check("rst_in1", 2'b00, 3'b101);
    @(posedge clk);
    step_check("rst_clk", 2'b00, 3'b101);

    // Walk A->B->C->D->A with in=0
    @(negedge clk);
    rst_n = 1'b1;
    in    = 1'b0;
    step_check("walk_A", 2'b00, 3'b111);
    @(posedge clk); step_check("walk_B", 2'b01, 3'b001);
    @(posedge clk); step_check("walk_C", 2'b10, 3'b000);
    @(posedge clk); step_check("walk_D", 2'b11, 3'b110);
    @(posedge clk); step_check("walk_A2", 2'b00, 3'b111);

    // Shortcut A->C->A with in=1
    in = 1'b1;
    step_check("A_in1", 2'b00, 3'b101);
    @(posedge clk); step_check("short_C", 2'b10, 3'b100);
    @(posedge clk); step_check("short_A", 2'b00, 3'b101);

    // A->B, then B with in=1 -> D, hold D
    in = 1'b0;
    step_check("A_in0", 2'b00, 3'b111);
    @(posedge clk); step_check("to_B", 2'b01, 3'b001);
    in = 1'b1;
    step_check("B_in1", 2'b01, 3'b011);
    @(posedge clk); step_check("to_D", 2'b11, 3'b110);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); step_check("D_hold", 2'b11, 3'b110);
    end

    // D->A, A->C, then async reset between edges
    in = 1'b0;
    @(posedge clk); step_check("D_to_A", 2'b00, 3'b111);
    in = 1'b1;
    @(posedge clk); step_check("A_to_C", 2'b10, 3'b100);
    in = 1'b0;
    step_check("C_in0", 2'b10, 3'b000);
    #1;
    rst_n = 1'b0;
    step_check("async_rst", 2'b00, 3'b111);
    @(posedge clk); step_check("rst_hold", 2'b00, 3'b111);

    // Release, then toggle in mid-cycle; the edge must take A to B
    @(negedge clk);
    rst_n = 1'b1;
    in    = 1'b0;
    step_check("tog_0", 2'b00, 3'b111);
    in = 1'b1;
    step_check("tog_1", 2'b00, 3'b101);
    in = 1'b0;
    step_check("tog_0b", 2'b00, 3'b111);
    @(posedge clk); step_check("tog_edge", 2'b01, 3'b001);

    // Random walk against the reference table
    mst = 2'b01;
    for (int k = 0; k < 40; k++) begin
      in = 1'($urandom_range(0, 1));
      step_check("rand_out", mst, model_out(mst, in));
      @(posedge clk);
      mst = model_next(mst, in);
      step_check("rand_st", mst, model_out(mst, in));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mealy_dec.md
MEALY_DEC -- requirements
Module: mealy_dec

Interface
REQ-001 Parameter RESET_STATE, default 2'b00 (A), SHALL set the state loaded on reset.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in  input  1  SHALL be the FSM input, sampled at rising clk; also feeds the Mealy output combinationally.
REQ-005 state  output  2  SHALL be the current registered state: A=00, B=01, C=10, D=11.
REQ-006 out  output  3  SHALL be the Mealy output, a combinational function of state and in.

Function
REQ-007 Output decode SHALL be purely combinational, with zero-cycle latency from in or state to out.
REQ-008 Output decode SHALL be:
- A: in=0 gives 111; in=1 gives 101.
- B: in=0 gives 001; in=1 gives 011.
- C: in=0 gives 000; in=1 gives 100.
- D: in=0 or in=1 gives 110.
REQ-009 Next-state SHALL be:
- A: in=0 goes to B; in=1 goes to C.
- B: in=0 goes to C; in=1 goes to D.
- C: in=0 goes to D; in=1 goes to A.
- D: in=0 goes to A; in=1 stays in D.
REQ-010 State SHALL advance exactly once per rising clk edge while rst_n=1; there is no enable or hold input.
REQ-011 A change of in between edges SHALL change out immediately but SHALL NOT change state until the next rising edge.
REQ-012 All 4 state encodings are legal; the decode SHALL be fully specified, with no latches and no X on out for any known state and in.
REQ-013 Out SHALL glitch-settle within the same cycle; no registered copy of out is provided.

Reset
REQ-014 rst_n=0 SHALL force state to RESET_STATE immediately, independent of clk.
REQ-015 During reset, out SHALL still follow REQ-008 for state=RESET_STATE and the current in (default: 111 for in=0, 101 for in=1).
REQ-016 Reset asserted mid-operation SHALL abandon the current state without completing the pending transition.
REQ-017 After release, the first transition SHALL occur on the first rising clk edge with rst_n=1.
REQ-018 Release coincident with a clk edge SHALL resolve to either RESET_STATE or its single legal successor, never an illegal value.

Structure
REQ-019 A shared package mealy_dec_pkg SHALL hold:
- the 2-bit state enum typedef (S_A, S_B, S_C, S_D);
- the 3-bit output typedef;
- named output constants for the 7 decode entries.
REQ-020 The combinational decoder SHALL be a sub-module mealy_out_dec, with ports state[1:0], in and out[2:0] and no clock.
REQ-021 The top SHALL contain only the state register, the next-state logic and the mealy_out_dec instance.

Verification
REQ-022 Decode sweep: force each of the 8 (state, in) pairs via the sequence from reset; out SHALL match REQ-008 within the same cycle (e.g. B,1 gives 011; D,0 gives 110).
REQ-023 Walk: reset, then in=0,0,0,0 over 4 edges; state SHALL be B, C, D, A, and out before each edge SHALL be 111, 001, 000, 110.
REQ-024 Hold and shortcut:
- from A, in=1, then in=1: state SHALL be C, then A.
- from D, in=1 for 3 edges: state SHALL stay D with out=110.
REQ-025 Async reset: in state C, drop rst_n between edges; state SHALL be 00 before the next edge, and out SHALL be 111 with in=0.
REQ-026 Mid-cycle input toggle: in state A, toggle in 0 to 1 to 0 between edges; out SHALL go 111, 101, 111, and the edge SHALL then take A to B.
